// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width/limit, sequencer state encoding, digit check.
// No logic state; used by the serial subtractor and its digit slice.
// Not applicable (package only).
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_NEG  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    function automatic logic bcd_digit_valid(input logic [BCD_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtract with borrow: diff = a - b - bin, folded back into 0..9.
// Latency: purely combinational.
// Backpressure: none; caller sequences the digits.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a_i,
    input  logic [BCD_W-1:0] b_i,
    input  logic             bin_i,
    output logic [BCD_W-1:0] diff_o,
    output logic             bout_o
);

    logic [BCD_W:0] raw;

    // Negative 5-bit result: low nibble + 10 (mod 16) lands back in 0..9.
    always_comb begin
        raw    = {1'b0, a_i} - {1'b0, b_i} - {{BCD_W{1'b0}}, bin_i};
        bout_o = raw[BCD_W];
        diff_o = bout_o ? (raw[BCD_W-1:0] + BCD_W'(10)) : raw[BCD_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Serial multi-digit BCD subtractor A - B - B_IN, LSD first, optional sign-magnitude pass.
// Latency: DIGITS+1 edges (2*DIGITS+1 with negate pass, 1 on invalid digit) incl. accept edge.
// Backpressure: START is only sampled in IDLE; requests while BUSY are dropped.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter bit SIGN_MAG = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    START,
    input  logic [BCD_W*DIGITS-1:0] A,
    input  logic [BCD_W*DIGITS-1:0] B,
    input  logic                    B_IN,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [BCD_W*DIGITS-1:0] DIFF,
    output logic                    NEG,
    output logic                    ERR
);

    localparam int            CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef logic [DIGITS-1:0][BCD_W-1:0] digits_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    digits_t       a_q, a_d;
    digits_t       b_q, b_d;
    digits_t       r_q, r_d;
    digits_t       diff_q, diff_d;
    logic          borrow_q, borrow_d;
    logic          neg_q, neg_d;
    logic          err_q, err_d;

    logic             ops_valid;
    logic             last_digit;
    logic [BCD_W-1:0] op_a, op_b, dig_diff;
    logic             dig_bout;
    digits_t          r_wr;

    always_comb begin
        ops_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(A[i*BCD_W +: BCD_W]) || !bcd_digit_valid(B[i*BCD_W +: BCD_W]))
                ops_valid = 1'b0;
        end
    end

    assign last_digit = (cnt_q == LAST);

    // The negate pass reuses the same slice as 0 - R_i - borrow.
    always_comb begin
        op_a = a_q[cnt_q];
        op_b = b_q[cnt_q];
        if (state_q == S_NEG) begin
            op_a = '0;
            op_b = r_q[cnt_q];
        end
    end

    bcd_digit_sub u_digit (
        .a_i    (op_a),
        .b_i    (op_b),
        .bin_i  (borrow_q),
        .diff_o (dig_diff),
        .bout_o (dig_bout)
    );

    always_comb begin
        r_wr        = r_q;
        r_wr[cnt_q] = dig_diff;
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (START) state_d = ops_valid ? S_SUB : S_FIN;
            S_SUB:  if (last_digit) state_d = (dig_bout && SIGN_MAG) ? S_NEG : S_FIN;
            S_NEG:  if (last_digit) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        BUSY = (state_q != S_IDLE);
        DONE = (state_q == S_FIN);
    end

    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        neg_d    = neg_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (ops_valid) begin
                        a_d      = A;
                        b_d      = B;
                        borrow_d = B_IN;
                        cnt_d    = '0;
                        r_d      = '0;
                    end else begin
                        diff_d = '0;
                        neg_d  = 1'b0;
                        err_d  = 1'b1;
                    end
                end
            end
            S_SUB: begin
                r_d      = r_wr;
                borrow_d = dig_bout;
                cnt_d    = last_digit ? '0 : cnt_q + CW'(1);
                if (last_digit) begin
                    if (dig_bout && SIGN_MAG) begin
                        borrow_d = 1'b0;
                    end else begin
                        diff_d = r_wr;
                        neg_d  = dig_bout;
                        err_d  = 1'b0;
                    end
                end
            end
            S_NEG: begin
                r_d      = r_wr;
                borrow_d = dig_bout;
                cnt_d    = last_digit ? '0 : cnt_q + CW'(1);
                if (last_digit) begin
                    // Only -10^DIGITS negates to all zeros; never flag a zero magnitude.
                    diff_d = r_wr;
                    neg_d  = (r_wr != '0);
                    err_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
        end
    end

    assign DIFF = diff_q;
    assign NEG  = neg_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Bench for bcd_serial_subtractor: sign-magnitude and raw instances against an integer model.
module tb_bcd_serial_subtractor;

    localparam int D = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        B_IN = 1'b0;

    logic        busy [2];
    logic        done [2];
    logic [15:0] diff [2];
    logic        neg  [2];
    logic        err  [2];

    bcd_serial_subtractor #(.DIGITS(D), .SIGN_MAG(1'b1)) u_sm (
        .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B), .B_IN(B_IN),
        .BUSY(busy[0]), .DONE(done[0]), .DIFF(diff[0]), .NEG(neg[0]), .ERR(err[0])
    );

    bcd_serial_subtractor #(.DIGITS(D), .SIGN_MAG(1'b0)) u_raw (
        .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B), .B_IN(B_IN),
        .BUSY(busy[1]), .DONE(done[1]), .DIFF(diff[1]), .NEG(neg[1]), .ERR(err[1])
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Model state: pending operation and the result the outputs must currently show.
    bit          p_valid [2];
    int          p_acc   [2];
    int          p_done  [2];
    logic [15:0] p_diff  [2];
    logic        p_neg   [2];
    logic        p_err   [2];
    logic [15:0] s_diff  [2];
    logic        s_neg   [2];
    logic        s_err   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] x);
        int v = 0;
        for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(x[i*4 +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int t = v % 10000;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bin, input bit sm,
                         output logic [15:0] md, output logic mn, output logic me, output int lat);
        bit bad_dig = 0;
        int v;
        for (int i = 0; i < D; i++)
            if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) bad_dig = 1;
        if (bad_dig) begin
            md = '0; mn = 1'b0; me = 1'b1; lat = 1;
        end else begin
            v  = bcd2int(a) - bcd2int(b) - int'(bin);
            me = 1'b0;
            if (v >= 0) begin
                md = int2bcd(v); mn = 1'b0; lat = D + 1;
            end else if (sm) begin
                md = int2bcd(-v); mn = (md != 16'h0); lat = 2 * D + 1;
            end else begin
                md = int2bcd(v + 10000); mn = 1'b1; lat = D + 1;
            end
        end
    endtask

    // Per-cycle compare of both instances against the model.
    always @(negedge CLK) begin
        if (RST_N) begin
            for (int j = 0; j < 2; j++) begin
                logic eb, ed;
                eb = p_valid[j] && edge_cnt >= p_acc[j] && edge_cnt <= p_done[j];
                ed = p_valid[j] && edge_cnt == p_done[j];
                if (ed) begin
                    s_diff[j] = p_diff[j];
                    s_neg[j]  = p_neg[j];
                    s_err[j]  = p_err[j];
                end
                chk($sformatf("busy%0d", j), 32'(busy[j]), 32'(eb));
                chk($sformatf("done%0d", j), 32'(done[j]), 32'(ed));
                chk($sformatf("diff%0d", j), 32'(diff[j]), 32'(s_diff[j]));
                chk($sformatf("neg%0d", j),  32'(neg[j]),  32'(s_neg[j]));
                chk($sformatf("err%0d", j),  32'(err[j]),  32'(s_err[j]));
                if (p_valid[j] && edge_cnt > p_done[j]) p_valid[j] = 0;
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bin);
        int lat;
        @(negedge CLK);
        A = a; B = b; B_IN = bin; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        A = 16'($urandom); B = 16'($urandom); B_IN = 1'($urandom);
        for (int j = 0; j < 2; j++) begin
            model(a, b, bin, (j == 0), p_diff[j], p_neg[j], p_err[j], lat);
            p_acc[j]   = edge_cnt;
            p_done[j]  = edge_cnt + lat - 1;
            p_valid[j] = 1;
        end
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic bin);
        issue(a, b, bin);
        repeat (2 * D + 4) @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        for (int j = 0; j < 2; j++) begin
            p_valid[j] = 0; s_diff[j] = '0; s_neg[j] = 1'b0; s_err[j] = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int j = 0; j < 2; j++) begin
            chk({tag, "_busy"}, 32'(busy[j]), 32'd0);
            chk({tag, "_done"}, 32'(done[j]), 32'd0);
            chk({tag, "_diff"}, 32'(diff[j]), 32'd0);
            chk({tag, "_neg"},  32'(neg[j]),  32'd0);
            chk({tag, "_err"},  32'(err[j]),  32'd0);
        end
    endtask

    initial begin
        int ndone;
        model_clear();
        @(posedge CLK);
        #1;
        chk_zero("reset");
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);

        run(16'h5432, 16'h1234, 1'b0);
        chk("basic_diff", 32'(diff[0]), 32'h4198);
        chk("basic_neg",  32'(neg[0]),  32'd0);
        chk("basic_err",  32'(err[0]),  32'd0);

        run(16'h0000, 16'h0001, 1'b0);
        chk("neg_sm_diff",  32'(diff[0]), 32'h0001);
        chk("neg_sm_neg",   32'(neg[0]),  32'd1);
        chk("neg_raw_diff", 32'(diff[1]), 32'h9999);
        chk("neg_raw_neg",  32'(neg[1]),  32'd1);

        run(16'h1000, 16'h0000, 1'b1);
        chk("chain_diff", 32'(diff[0]), 32'h0999);
        chk("chain_neg",  32'(neg[0]),  32'd0);

        run(16'h9999, 16'h9999, 1'b0);
        chk("equal_diff", 32'(diff[0]), 32'h0000);
        chk("equal_neg",  32'(neg[0]),  32'd0);

        run(16'h0000, 16'h0000, 1'b1);
        chk("zbin_diff", 32'(diff[0]), 32'h0001);
        chk("zbin_neg",  32'(neg[0]),  32'd1);

        run(16'h00A0, 16'h0001, 1'b0);
        chk("inv_err",  32'(err[0]),  32'd1);
        chk("inv_diff", 32'(diff[0]), 32'h0000);

        run(16'h0002, 16'h0001, 1'b0);
        chk("after_inv_err",  32'(err[0]),  32'd0);
        chk("after_inv_diff", 32'(diff[0]), 32'h0001);

        // START pulsed two cycles into an operation must be dropped.
        issue(16'h0300, 16'h0100, 1'b0);
        ndone = 0;
        @(posedge CLK);
        @(negedge CLK);
        ndone += int'(done[0]);
        A = 16'h9999; B = 16'h0001; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        for (int c = 0; c < 2 * D + 4; c++) begin
            @(negedge CLK);
            ndone += int'(done[0]);
        end
        chk("busy_start_diff",  32'(diff[0]), 32'h0200);
        chk("busy_start_ndone", 32'(ndone),   32'd1);

        // Asynchronous reset in the middle of the subtract pass.
        issue(16'h0444, 16'h0111, 1'b0);
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        chk_zero("midreset");
        model_clear();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);

        run(16'h0050, 16'h0025, 1'b0);
        chk("post_reset_diff", 32'(diff[0]), 32'h0025);
        chk("post_reset_neg",  32'(neg[0]),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
